// File: rtl/sc_sync_pkg.sv
// rtl/sc_sync_pkg.sv - shared types and constants for the Schmidl-Cox sync blocks
//
// Purpose: common state encoding, event layout and metric width shared by the
//          Schmidl-Cox synchronisation datapath and its benches.
// Ports:   none (package)
package sc_sync_pkg;

   localparam int METRIC_W    = 32;
   localparam int EVENT_IDX_W = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEARCH  = 2'd1,
      EMIT    = 2'd2,
      HOLDOFF = 2'd3
   } sc_peak_state_t;

   typedef struct packed {
      logic [EVENT_IDX_W-1:0] index;
      logic [METRIC_W-1:0]    value;
   } sc_peak_event_t;

endpackage

// File: rtl/sc_event_reg.sv
// rtl/sc_event_reg.sv - one-deep stream holding register with drop-on-full overflow
//
// Purpose: holds a single timing event until the consumer accepts it. A load
//          while the held event is still pending (and not being accepted this
//          cycle) is dropped and the sticky overflow flag is raised.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clear         synchronous clear (drops held event and overflow)
//   load          present a new event this cycle
//   load_index    sample index of the new event
//   load_value    metric value of the new event
//   o_tvalid      event valid
//   o_tready      event accepted
//   o_tdata       held sample index
//   o_peak        held metric value
//   overflow      sticky drop flag
module sc_event_reg
   import sc_sync_pkg::*;
#(
   parameter int IDX_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                load,
   input  logic [IDX_W-1:0]    load_index,
   input  logic [METRIC_W-1:0] load_value,
   output logic                o_tvalid,
   input  logic                o_tready,
   output logic [IDX_W-1:0]    o_tdata,
   output logic [METRIC_W-1:0] o_peak,
   output logic                overflow
);

   logic                valid_q;
   logic [IDX_W-1:0]    index_q;
   logic [METRIC_W-1:0] value_q;
   logic                ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         index_q <= '0;
         value_q <= '0;
         ovf_q   <= 1'b0;
      end else if (clear) begin
         valid_q <= 1'b0;
         index_q <= '0;
         value_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         // Slot is free if empty or being drained this very cycle.
         if (load && (!valid_q || o_tready)) begin
            valid_q <= 1'b1;
            index_q <= load_index;
            value_q <= load_value;
         end else begin
            if (load) begin
               ovf_q <= 1'b1;
            end
            if (valid_q && o_tready) begin
               valid_q <= 1'b0;
            end
         end
      end
   end

   assign o_tvalid = valid_q;
   assign o_tdata  = index_q;
   assign o_peak   = value_q;
   assign overflow = ovf_q;

endmodule

// File: rtl/schmidl_cox_peak_detector.sv
// rtl/schmidl_cox_peak_detector.sv - threshold-triggered windowed peak search on M(d)
//
// Purpose: watches the normalized timing metric, starts a fixed-length search
//          window at the first threshold crossing, and reports the absolute
//          sample index and value of the window maximum as one event. After
//          each event the detector ignores HOLDOFF_LEN beats before re-arming.
// Ports:
//   clk, reset    clock, asynchronous active-low reset
//   clear         synchronous clear, same effect as reset
//   threshold     unsigned detection threshold, used only while armed
//   i_tdata       metric M(d); i_tvalid/i_tready handshake; i_tlast ignored
//   o_tdata       peak sample index; o_peak peak metric; o_tvalid/o_tready handshake
//   overflow      sticky, set when an event is dropped
//   state_dbg     current FSM state
module schmidl_cox_peak_detector
   import sc_sync_pkg::*;
#(
   parameter int WINDOW_LEN  = 256,
   parameter int HOLDOFF_LEN = 1024,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic [31:0]          threshold,
   input  logic [31:0]          i_tdata,
   input  logic                 i_tlast,
   input  logic                 i_tvalid,
   output logic                 i_tready,
   output logic [CNT_WIDTH-1:0] o_tdata,
   output logic [31:0]          o_peak,
   output logic                 o_tvalid,
   input  logic                 o_tready,
   output logic                 overflow,
   output logic [1:0]           state_dbg
);

   localparam int WIN_W  = $clog2(WINDOW_LEN + 1);
   localparam int HOLD_W = $clog2(HOLDOFF_LEN + 2);
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_LEN - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLDOFF_LEN > 0) ? HOLDOFF_LEN - 1 : 0);

   sc_peak_state_t       state, state_nxt;
   logic [CNT_WIDTH-1:0] idx_cnt;
   logic [WIN_W-1:0]     win_cnt;
   logic [HOLD_W-1:0]    hold_cnt;
   logic [METRIC_W-1:0]  max_val;
   logic [CNT_WIDTH-1:0] max_idx;
   logic                 beat;
   logic                 armed;
   logic                 trigger;
   logic                 window_done;
   logic                 emit;
   logic                 unused_tlast;

   assign unused_tlast = i_tlast;

   // Never back-pressures; only deasserted while held in reset.
   assign i_tready = reset;
   assign beat     = i_tvalid & i_tready;

   // With no holdoff the EMIT cycle is already armed, so a crossing beat
   // arriving during EMIT starts the next search.
   assign armed       = (state == IDLE) || ((state == EMIT) && (HOLDOFF_LEN == 0));
   assign trigger     = beat && armed && (i_tdata >= threshold);
   assign window_done = beat && (state == SEARCH) && (win_cnt == WIN_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else if (clear) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (trigger) begin
               state_nxt = (WINDOW_LEN == 1) ? EMIT : SEARCH;
            end
         end
         SEARCH: begin
            if (window_done) begin
               state_nxt = EMIT;
            end
         end
         EMIT: begin
            if (HOLDOFF_LEN == 0) begin
               if (trigger) begin
                  state_nxt = (WINDOW_LEN == 1) ? EMIT : SEARCH;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (beat && (HOLDOFF_LEN == 1)) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = HOLDOFF;
            end
         end
         HOLDOFF: begin
            if (beat && (hold_cnt == HOLD_LAST)) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      emit      = (state == EMIT);
      state_dbg = state;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_cnt  <= '0;
         win_cnt  <= '0;
         hold_cnt <= '0;
         max_val  <= '0;
         max_idx  <= '0;
      end else if (clear) begin
         idx_cnt  <= '0;
         win_cnt  <= '0;
         hold_cnt <= '0;
         max_val  <= '0;
         max_idx  <= '0;
      end else begin
         if (beat) begin
            idx_cnt <= idx_cnt + 1'b1;
         end

         if (trigger) begin
            max_val <= i_tdata;
            max_idx <= idx_cnt;
            win_cnt <= WIN_W'(1);
         end else if ((state == SEARCH) && beat) begin
            win_cnt <= win_cnt + 1'b1;
            // Strict compare: equal values keep the earliest index.
            if (i_tdata > max_val) begin
               max_val <= i_tdata;
               max_idx <= idx_cnt;
            end
         end

         // A beat landing in the EMIT cycle is the first holdoff beat.
         if (state == EMIT) begin
            hold_cnt <= beat ? HOLD_W'(1) : '0;
         end else if ((state == HOLDOFF) && beat) begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

   sc_event_reg #(
      .IDX_W (CNT_WIDTH)
   ) u_event_reg (
      .clk        (clk),
      .rst_n      (reset),
      .clear      (clear),
      .load       (emit),
      .load_index (max_idx),
      .load_value (max_val),
      .o_tvalid   (o_tvalid),
      .o_tready   (o_tready),
      .o_tdata    (o_tdata),
      .o_peak     (o_peak),
      .overflow   (overflow)
   );

endmodule

// File: tb/tb_schmidl_cox_peak_detector.sv
// tb/tb_schmidl_cox_peak_detector.sv - directed scoreboard bench for the peak detector
module tb_schmidl_cox_peak_detector;
   import sc_sync_pkg::*;

   localparam int WL = 4;
   localparam int HL = 8;
   localparam int CW = 8;

   logic          clk;
   logic          reset;
   logic          clear;
   logic [31:0]   threshold;
   logic [31:0]   i_tdata;
   logic          i_tlast;
   logic          i_tvalid;
   logic          i_tready;
   logic [CW-1:0] o_tdata;
   logic [31:0]   o_peak;
   logic          o_tvalid;
   logic          o_tready;
   logic          overflow;
   logic [1:0]    state_dbg;

   sc_peak_event_t exp_q[$];
   sc_peak_event_t mon_e;
   int            checks;
   int            passes;
   int            fails;
   logic [CW-1:0] bidx;
   logic [CW-1:0] mark;

   schmidl_cox_peak_detector #(
      .WINDOW_LEN  (WL),
      .HOLDOFF_LEN (HL),
      .CNT_WIDTH   (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .threshold (threshold),
      .i_tdata   (i_tdata),
      .i_tlast   (i_tlast),
      .i_tvalid  (i_tvalid),
      .i_tready  (i_tready),
      .o_tdata   (o_tdata),
      .o_peak    (o_peak),
      .o_tvalid  (o_tvalid),
      .o_tready  (o_tready),
      .overflow  (overflow),
      .state_dbg (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input logic [CW-1:0] idx, input logic [31:0] val);
      sc_peak_event_t e;
      e.index = EVENT_IDX_W'(idx);
      e.value = val;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [31:0] d, input bit gaps);
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
            i_tvalid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      i_tvalid = 1'b1;
      i_tdata  = d;
      bidx     = bidx + 1'b1;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      i_tvalid = 1'b0;
      i_tdata  = '0;
   endtask

   task automatic clear_dut();
      @(posedge clk);
      #1;
      i_tvalid = 1'b0;
      clear    = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      bidx  = '0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk(tag, exp_q.size(), 0);
   endtask

   // Consumer side of the scoreboard: every accepted event must match the
   // oldest expected entry.
   always @(negedge clk) begin
      if (reset && !clear && o_tvalid && o_tready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_event", 32'(o_tdata), 32'hFFFF_FFFF);
         end else begin
            mon_e = exp_q.pop_front();
            chk("event_index", 32'(o_tdata), mon_e.index);
            chk("event_peak", o_peak, mon_e.value);
         end
      end
   end

   initial begin
      checks    = 0;
      passes    = 0;
      fails     = 0;
      bidx      = '0;
      reset     = 1'b0;
      clear     = 1'b0;
      threshold = 32'd100;
      i_tdata   = '0;
      i_tlast   = 1'b0;
      i_tvalid  = 1'b0;
      o_tready  = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", 32'(o_tvalid), 0);
      chk("rst_tdata", 32'(o_tdata), 0);
      chk("rst_peak", o_peak, 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_state", 32'(state_dbg), 32'(IDLE));
      chk("rst_itready", 32'(i_tready), 0);
      reset = 1'b1;
      #1;
      chk("run_itready", 32'(i_tready), 1);

      // 1: basic detection and latency
      repeat (10) send(32'd0, 1'b0);
      send(32'd50, 1'b0);
      send(32'd150, 1'b0);
      send(32'd300, 1'b0);
      send(32'd200, 1'b0);
      send(32'd120, 1'b0);
      push_exp(8'd12, 32'd300);
      idle();
      chk("lat_emit_state", 32'(state_dbg), 32'(EMIT));
      chk("lat_not_yet", 32'(o_tvalid), 0);
      @(posedge clk);
      #1;
      chk("lat_valid", 32'(o_tvalid), 1);
      chk("lat_holdoff_state", 32'(state_dbg), 32'(HOLDOFF));
      drain("t1_drain");
      chk("t1_overflow", 32'(overflow), 0);
      repeat (10) send(32'd0, 1'b0);

      // 2: tie keeps earliest; dip inside the window
      clear_dut();
      repeat (5) send(32'd0, 1'b0);
      send(32'd200, 1'b0);
      send(32'd200, 1'b0);
      send(32'd50, 1'b0);
      send(32'd150, 1'b0);
      push_exp(8'd5, 32'd200);
      repeat (10) send(32'd0, 1'b0);
      mark = bidx;
      send(32'd120, 1'b0);
      send(32'd30, 1'b0);
      send(32'd400, 1'b0);
      send(32'd10, 1'b0);
      push_exp(mark + 8'd2, 32'd400);
      idle();
      drain("t2_drain");
      repeat (10) send(32'd0, 1'b0);

      // 3: holdoff boundary (EMIT-cycle beat counts as first holdoff beat)
      mark = bidx;
      send(32'd150, 1'b0);
      repeat (3) send(32'd0, 1'b0);
      push_exp(mark, 32'd150);
      send(32'd0, 1'b0);
      send(32'd0, 1'b0);
      send(32'd500, 1'b0);
      repeat (4) send(32'd0, 1'b0);
      send(32'd500, 1'b0);
      send(32'd180, 1'b0);
      repeat (3) send(32'd0, 1'b0);
      push_exp(mark + 8'd12, 32'd180);
      repeat (10) send(32'd0, 1'b0);
      idle();
      drain("t3_drain");
      chk("t3_overflow", 32'(overflow), 0);

      // 4: back-pressure, second event dropped
      o_tready = 1'b0;
      mark = bidx;
      send(32'd300, 1'b0);
      repeat (3) send(32'd0, 1'b0);
      push_exp(mark, 32'd300);
      repeat (9) send(32'd0, 1'b0);
      send(32'd400, 1'b0);
      repeat (3) send(32'd0, 1'b0);
      repeat (10) send(32'd0, 1'b0);
      idle();
      repeat (3) @(posedge clk);
      #1;
      chk("bp_tvalid", 32'(o_tvalid), 1);
      chk("bp_tdata_held", 32'(o_tdata), 32'(mark));
      chk("bp_peak_held", o_peak, 32'd300);
      chk("bp_overflow", 32'(overflow), 1);
      chk("bp_pending", exp_q.size(), 1);
      o_tready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_accepted", 32'(o_tvalid), 0);
      chk("bp_drained", exp_q.size(), 0);
      chk("bp_overflow_sticky", 32'(overflow), 1);
      clear_dut();
      #1;
      chk("clr_overflow", 32'(overflow), 0);

      // 5: reset mid-search
      send(32'd0, 1'b0);
      send(32'd200, 1'b0);
      send(32'd0, 1'b0);
      @(posedge clk);
      #2;
      reset    = 1'b0;
      i_tvalid = 1'b0;
      #1;
      chk("mid_rst_tvalid", 32'(o_tvalid), 0);
      chk("mid_rst_state", 32'(state_dbg), 32'(IDLE));
      chk("mid_rst_itready", 32'(i_tready), 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      bidx  = '0;
      repeat (3) send(32'd0, 1'b0);
      send(32'd250, 1'b0);
      repeat (3) send(32'd0, 1'b0);
      push_exp(8'd3, 32'd250);
      repeat (10) send(32'd0, 1'b0);
      idle();
      drain("t5_drain");

      // 6: gapped input, then index wrap inside a window
      clear_dut();
      repeat (10) send(32'd0, 1'b1);
      send(32'd50, 1'b1);
      send(32'd150, 1'b1);
      send(32'd300, 1'b1);
      send(32'd200, 1'b1);
      send(32'd120, 1'b1);
      push_exp(8'd12, 32'd300);
      repeat (12) send(32'd0, 1'b1);
      idle();
      drain("t6_drain");
      while (bidx != 8'd254) send(32'd0, 1'b0);
      send(32'd120, 1'b0);
      send(32'd130, 1'b0);
      send(32'd600, 1'b0);
      send(32'd10, 1'b0);
      push_exp(8'd0, 32'd600);
      repeat (10) send(32'd0, 1'b0);
      idle();
      drain("wrap_drain");
      chk("final_overflow", 32'(overflow), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
